// File: rtl/serial_subtractor16_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// master drives operands and accepts results; slave is the subtractor itself.
interface serial_subtractor16_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, d, bout, zero, ovf
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, d, bout, zero, ovf
   );
endinterface

// File: rtl/serial_subtractor16.sv
// Multi-cycle subtractor D = A - B - BIN, one DIGIT-wide slice per clock,
// using a registered borrow chain folded into an add of the inverted subtrahend.
module serial_subtractor16 #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_subtractor16_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_reg, state_next;
   logic [IDXW-1:0]  idx_reg;
   logic [WIDTH-1:0] a_reg, b_reg, d_reg, d_next;
   logic             borrow_reg, bout_reg, zero_reg, ovf_reg;
   logic [DIGIT-1:0] a_dig [NDIG];
   logic [DIGIT-1:0] b_dig [NDIG];
   logic [DIGIT:0]   sum;
   logic [DIGIT-1:0] s;
   logic             c;
   logic             last;
   logic             accept;

   // d_next merges the freshly computed slice into the held result so that
   // the zero flag can see the complete difference on the final digit edge.
   for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
      assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT];
      assign d_next[gi*DIGIT +: DIGIT] =
         (state_reg == BUSY && idx_reg == IDXW'(gi)) ? s : d_reg[gi*DIGIT +: DIGIT];
   end

   always_comb begin
      sum = {1'b0, a_dig[idx_reg]} + {1'b0, ~b_dig[idx_reg]} + {{DIGIT{1'b0}}, ~borrow_reg};
      s   = sum[DIGIT-1:0];
      c   = sum[DIGIT];
   end

   assign last   = (idx_reg == IDXW'(NDIG - 1));
   assign accept = (state_reg == IDLE) && bus.in_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.in_valid)  state_next = BUSY;
         BUSY:    if (last)          state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_reg    <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         d_reg      <= '0;
         borrow_reg <= 1'b0;
         bout_reg   <= 1'b0;
         zero_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         if (accept) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            borrow_reg <= bus.bin;
            idx_reg    <= '0;
         end
         if (state_reg == BUSY) begin
            d_reg      <= d_next;
            borrow_reg <= ~c;
            idx_reg    <= last ? '0 : idx_reg + 1'b1;
            if (last) begin
               bout_reg <= ~c;
               zero_reg <= (d_next == '0);
               ovf_reg  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                           (d_next[WIDTH-1] != a_reg[WIDTH-1]);
            end
         end
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.d         = d_reg;
   assign bus.bout      = bout_reg;
   assign bus.zero      = zero_reg;
   assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_serial_subtractor16.sv
// Randomized and directed checks of serial_subtractor16 against an
// arithmetic reference model.
module tb_serial_subtractor16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;

   serial_subtractor16_if #(.WIDTH(16)) bus ();

   serial_subtractor16 #(.WIDTH(16), .DIGIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                 output logic [15:0] d, output logic bout,
                                 output logic zero, output logic ovf);
      int ua, ub, diff, sa, sb, r;
      ua   = int'(a);
      ub   = int'(b);
      diff = ua - ub - int'(bin);
      d    = diff[15:0];
      bout = (ua < ub + int'(bin));
      zero = (d == 16'h0000);
      sa   = int'($signed(a));
      sb   = int'($signed(b));
      r    = sa - sb - int'(bin);
      ovf  = (r > 32767) || (r < -32768);
   endfunction

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin, input int stall);
      logic [15:0] ed;
      logic        eb, ez, eo;
      int          lat;
      model(a, b, bin, ed, eb, ez, eo);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.bin = bin;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      lat = 0;
      // Garbage operands and in_valid pulses while busy must be ignored.
      while (!bus.out_valid && lat < 20) begin
         check("in_ready_busy", 32'(bus.in_ready), 32'd0);
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.a = 16'($urandom); bus.b = 16'($urandom);
         bus.bin = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      bus.in_valid = 1'b0;
      check("latency", 32'(lat), 32'd4);
      check("d", 32'(bus.d), 32'(ed));
      check("bout", 32'(bus.bout), 32'(eb));
      check("zero", 32'(bus.zero), 32'(ez));
      check("ovf", 32'(bus.ovf), 32'(eo));
      $display("op a=%h b=%h bin=%0d -> d=%h bout=%0d zero=%0d ovf=%0d (exp d=%h bout=%0d zero=%0d ovf=%0d)",
               a, b, bin, bus.d, bus.bout, bus.zero, bus.ovf, ed, eb, ez, eo);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_d", 32'(bus.d), 32'(ed));
         check("hold_bout", 32'(bus.bout), 32'(eb));
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_valid", 32'(bus.out_valid), 32'd0);
      check("release_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] ed;
      logic        eb, ez, eo;
      int          acc[$];
      int          nres;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.bin = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_d", 32'(bus.d), 32'd0);
      check("rst_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'd0);
      rst = 1'b0;

      run_op(16'h1234, 16'h0234, 1'b0, 3);
      run_op(16'h0000, 16'h0001, 1'b0, 0);
      run_op(16'h0000, 16'h0000, 1'b1, 1);
      run_op(16'h8000, 16'h0001, 1'b0, 0);
      run_op(16'h5555, 16'h5555, 1'b0, 2);
      run_op(16'h8000, 16'h0000, 1'b1, 0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
      for (int i = 0; i < 25; i++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

      // Back-to-back accepts with out_ready held high.
      model(16'hA5A5, 16'h1357, 1'b1, ed, eb, ez, eo);
      @(negedge clk);
      bus.a = 16'hA5A5; bus.b = 16'h1357; bus.bin = 1'b1;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      nres = 0;
      for (int cyc = 0; cyc < 40 && nres < 2; cyc++) begin
         if (bus.in_valid && bus.in_ready) acc.push_back(cyc);
         else if (acc.size() >= 2) bus.in_valid = 1'b0;
         if (bus.out_valid) begin
            check("b2b_d", 32'(bus.d), 32'(ed));
            check("b2b_bout", 32'(bus.bout), 32'(eb));
            nres++;
         end
         if (nres < 2) @(negedge clk);
      end
      check("b2b_results", 32'(nres), 32'd2);
      if (acc.size() >= 2) check("b2b_spacing", 32'(acc[1] - acc[0]), 32'd6);
      else check("b2b_accepts", 32'(acc.size()), 32'd2);
      $display("b2b accepts=%0d results=%0d", acc.size(), nres);
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // Reset while processing digit 2.
      @(negedge clk);
      bus.a = 16'hFFFF; bus.b = 16'h1111; bus.bin = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("mid_busy", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_d", 32'(bus.d), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      $display("mid-op reset d=%h out_valid=%0d in_ready=%0d", bus.d, bus.out_valid, bus.in_ready);
      @(negedge clk);
      rst = 1'b0;
      run_op(16'h00FF, 16'h000F, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/serial_subtractor16.md
Name: serial_subtractor16

Overview:
- Nibble-serial multi-cycle subtractor: D = A - B - BIN. It is the inverse-direction companion to the team's 16-bit carry-select adder.
- Processes one DIGIT-wide slice per clock using a registered borrow chain. Each slice is computed as A + ~B + ~borrow, which reuses the ripple digit structure.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Trades latency for area against the single-cycle adder path.

Parameters:
- WIDTH, 16: operand and result width.
- DIGIT, 4: bits processed per cycle. WIDTH must be an integer multiple of DIGIT.
- NDIG, WIDTH/DIGIT (derived localparam): number of digit cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set on a/b/bin is valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result outputs are valid.
- out_ready  in  1  consumer accepts the result.
- d  out  WIDTH  difference, registered.
- bout  out  1  borrow-out from the MSB digit, registered.
- zero  out  1  d == 0, registered.
- ovf  out  1  signed (two's-complement) overflow, registered.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; digit index goes to 0.
  - d=0, bout=0, zero=0, ovf=0, out_valid=0.
  - in_ready=1 immediately after reset, because it is decoded combinationally from the IDLE state.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready at an edge, latch a, b and bin into internal operand registers, clear idx, set borrow=bin, go to BUSY.
  - BUSY: in_ready=0; in_valid is ignored. Each edge:
    - computes {c, s} = a_r[idx] + ~b_r[idx] + ~borrow, where [idx] is the DIGIT-wide slice;
    - writes s into d slice idx;
    - sets borrow = ~c;
    - increments idx.
  - BUSY exit: on the edge that processes slice NDIG-1, go to DONE. On that same edge:
    - set out_valid=1 and bout=final borrow;
    - zero = (complete d == 0);
    - ovf = (a_r[MSB] != b_r[MSB]) && (d[MSB] != a_r[MSB]).
  - DONE: out_valid=1; d, bout, zero and ovf are held stable. On out_ready, go to IDLE and clear out_valid on that edge. The block does not accept new operands on the same edge it releases a result.
- Latency and throughput:
  - Operands are accepted at edge E0; digit k is written at edge E(k+1); out_valid rises at edge E(NDIG), which is E4 with the defaults.
  - Minimum spacing between accepts is NDIG+2 cycles (6 with the defaults) when out_ready is held high.
- Intermediate visibility: d may show partial results during BUSY. Consumers must sample d only when out_valid=1.
- Operand inputs: a, b and bin may change freely after acceptance; only the latched copies are used.
- Backpressure: out_ready low holds DONE indefinitely with all outputs stable.
- Reset mid-operation (BUSY or DONE): the operation is aborted and all outputs return to their reset values. There is no partial result and no spurious out_valid.
- Wrap-around: the result is modulo 2^WIDTH; bout=1 exactly when A < B + BIN as unsigned values.

Test Plan:
- Basic subtract: a=16'h1234, b=16'h0234, bin=0 -> d=16'h1000, bout=0, zero=0, ovf=0. out_valid rises 4 edges after acceptance.
- Unsigned underflow: a=16'h0000, b=16'h0001, bin=0 -> d=16'hFFFF, bout=1, ovf=0. Also a=0, b=0, bin=1 -> d=16'hFFFF, bout=1.
- Signed overflow and zero:
  - a=16'h8000, b=16'h0001 -> d=16'h7FFF, ovf=1, bout=0.
  - a=16'h5555, b=16'h5555 -> d=16'h0000, zero=1, bout=0.
- Handshakes:
  - Hold out_ready=0 for 3 cycles in DONE -> outputs stable and out_valid stays 1.
  - Pulse in_valid with new operands during BUSY -> ignored and in_ready stays 0.
  - With out_ready held high, two back-to-back accepts are 6 cycles apart.
- Reset mid-operation: assert rst at BUSY digit 2 -> out_valid=0, d=0, in_ready=1 after reset. The next operation, a=16'h00FF, b=16'h000F, produces d=16'h00F0 correctly.
